game_vga_monitor: RTL and testbench

- Receive-side checker for the VGA stream that the game top level emits on hsync, vsync and rgb.
- Re-derives pixel coordinates from the sync pulses, checks line and frame timing against parameters, and locks once a clean frame has been seen.
- Counts lit (non-black) pixels per frame.
- Used in the bench and as on-chip self-test on the same pixel clock as the game.

---
 rtl/game_vga_monitor.sv | 195 +++++++++++++++++++
 tb/tb_game_vga_monitor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/game_vga_monitor.sv
// Receive-side VGA timing checker: recovers pixel coordinates from hsync/vsync,
// verifies line/frame timing, locks after a clean frame and counts lit pixels.
module game_vga_monitor #(
    parameter int H_DISPLAY       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_DISPLAY       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int X_WIDTH         = 10,
    parameter int Y_WIDTH         = 10,
    parameter int COUNT_WIDTH     = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic [2:0]             rgb,
    output logic                   locked,
    output logic                   pixel_valid,
    output logic [X_WIDTH-1:0]     pixel_x,
    output logic [Y_WIDTH-1:0]     pixel_y,
    output logic [2:0]             pixel_rgb,
    output logic                   h_error,
    output logic                   v_error,
    output logic [7:0]             error_count,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] frame_lit_count
);
    localparam int CW = 12;
    localparam logic [CW-1:0] H_TOTAL_C = CW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK);
    localparam logic [CW-1:0] V_TOTAL_C = CW'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK);
    localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
    localparam logic [CW-1:0] H_VIS0_C  = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] H_VIS1_C  = CW'(H_SYNC + H_BACK + H_DISPLAY);
    localparam logic [CW-1:0] V_VIS0_C  = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] V_VIS1_C  = CW'(V_SYNC + V_BACK + V_DISPLAY);

    typedef enum logic [1:0] {S_SEARCH, S_LINE, S_FRAME, S_LOCKED} state_t;

    logic                   r_hs_q, r_vs_q, r_hs_d, r_vs_d;
    logic [2:0]             r_rgb_q, r_rgb_d;
    logic [CW-1:0]          r_h_cnt, r_v_cnt;
    logic                   r_h_seen, r_v_seen;
    state_t                 r_state, w_state_nx;
    logic                   r_dirty, w_dirty_nx;
    logic                   r_locked, r_pixel_valid, r_h_error, r_v_error, r_frame_done;
    logic [X_WIDTH-1:0]     r_pixel_x;
    logic [Y_WIDTH-1:0]     r_pixel_y;
    logic [2:0]             r_pixel_rgb;
    logic [7:0]             r_err_cnt;
    logic [COUNT_WIDTH-1:0] r_lit, r_frame_lit;

    logic          w_hs_edge, w_hs_fall, w_vs_edge;
    logic          w_h_err, w_v_err, w_vis;
    logic [CW-1:0] w_px, w_py;

    // Stage 1: sync normalised so 1 = asserted; reset history reads as deasserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hs_q  <= 1'b0;
            r_vs_q  <= 1'b0;
            r_hs_d  <= 1'b0;
            r_vs_d  <= 1'b0;
            r_rgb_q <= 3'b000;
            r_rgb_d <= 3'b000;
        end else begin
            r_hs_q  <= hsync ^ SYNC_ACTIVE_LOW;
            r_vs_q  <= vsync ^ SYNC_ACTIVE_LOW;
            r_hs_d  <= r_hs_q;
            r_vs_d  <= r_vs_q;
            r_rgb_q <= rgb;
            r_rgb_d <= r_rgb_q;
        end
    end

    assign w_hs_edge = r_hs_q & ~r_hs_d;
    assign w_hs_fall = ~r_hs_q & r_hs_d;
    assign w_vs_edge = r_vs_q & ~r_vs_d;

    // r_h_cnt still holds the last sample's count when an edge is seen, hence +1.
    assign w_h_err = (w_hs_edge & r_h_seen & ((r_h_cnt + 12'd1) != H_TOTAL_C)) |
                     (w_hs_fall & ((r_h_cnt + 12'd1) != H_SYNC_C));
    assign w_v_err = w_vs_edge & r_v_seen & ((r_v_cnt + 12'd1) != V_TOTAL_C);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_h_seen <= 1'b0;
            r_v_seen <= 1'b0;
        end else begin
            if (w_hs_edge)
                r_h_cnt <= '0;
            else if (r_h_cnt != '1)
                r_h_cnt <= r_h_cnt + 12'd1;
            if (w_vs_edge)
                r_v_cnt <= '0;
            else if (w_hs_edge && r_v_cnt != '1)
                r_v_cnt <= r_v_cnt + 12'd1;
            r_h_seen <= r_h_seen | w_hs_edge;
            r_v_seen <= r_v_seen | w_vs_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_SEARCH;
            r_dirty <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_dirty <= w_dirty_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_dirty_nx = r_dirty;
        case (r_state)
            S_SEARCH: if (w_hs_edge) w_state_nx = S_LINE;
            S_LINE: begin
                if (w_vs_edge) begin
                    w_state_nx = S_FRAME;
                    w_dirty_nx = 1'b0;
                end
            end
            S_FRAME: begin
                if (w_h_err) w_dirty_nx = 1'b1;
                // An h_error on the closing edge belongs to this frame's last line.
                if (w_vs_edge) begin
                    if (!w_v_err && !r_dirty && !w_h_err) w_state_nx = S_LOCKED;
                    w_dirty_nx = 1'b0;
                end
            end
            S_LOCKED: if (w_h_err || w_v_err) w_state_nx = S_LINE;
            default: w_state_nx = S_SEARCH;
        endcase
    end

    assign w_vis = (r_h_cnt >= H_VIS0_C) && (r_h_cnt < H_VIS1_C) &&
                   (r_v_cnt >= V_VIS0_C) && (r_v_cnt < V_VIS1_C);
    assign w_px  = r_h_cnt - H_VIS0_C;
    assign w_py  = r_v_cnt - V_VIS0_C;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_locked      <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_pixel_rgb   <= 3'b000;
            r_h_error     <= 1'b0;
            r_v_error     <= 1'b0;
            r_err_cnt     <= 8'd0;
            r_frame_done  <= 1'b0;
            r_frame_lit   <= '0;
            r_lit         <= '0;
        end else begin
            r_locked      <= (r_state == S_LOCKED);
            r_pixel_valid <= (r_state == S_LOCKED) && w_vis;
            r_pixel_x     <= w_vis ? X_WIDTH'(w_px) : '0;
            r_pixel_y     <= w_vis ? Y_WIDTH'(w_py) : '0;
            r_pixel_rgb   <= w_vis ? r_rgb_d : 3'b000;
            r_h_error     <= w_h_err;
            r_v_error     <= w_v_err;
            r_frame_done  <= 1'b0;
            if ((w_h_err || w_v_err) && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
            // A frame that ends on a timing error is not reported.
            if (w_vs_edge) begin
                if (r_state == S_LOCKED && !w_h_err && !w_v_err) begin
                    r_frame_lit  <= r_lit;
                    r_frame_done <= 1'b1;
                end
                r_lit <= '0;
            end else if (r_pixel_valid && r_pixel_rgb != 3'b000 && r_lit != '1) begin
                r_lit <= r_lit + COUNT_WIDTH'(1);
            end
        end
    end

    assign locked          = r_locked;
    assign pixel_valid     = r_pixel_valid;
    assign pixel_x         = r_pixel_x;
    assign pixel_y         = r_pixel_y;
    assign pixel_rgb       = r_pixel_rgb;
    assign h_error         = r_h_error;
    assign v_error         = r_v_error;
    assign error_count     = r_err_cnt;
    assign frame_done      = r_frame_done;
    assign frame_lit_count = r_frame_lit;
endmodule

// File: tb/tb_game_vga_monitor.sv
// Scoreboard bench for game_vga_monitor on a shrunken 25x17 raster so that
// many whole frames fit in a short run.
module tb_game_vga_monitor;
    localparam int HD = 16, HF = 2, HS = 4, HB = 3;
    localparam int VD = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    logic        clk = 1'b0, reset = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0]  rgb = 3'b000;
    logic        locked, pixel_valid, h_error, v_error, frame_done;
    logic [9:0]  pixel_x, pixel_y;
    logic [2:0]  pixel_rgb;
    logic [7:0]  error_count;
    logic [18:0] frame_lit_count;

    game_vga_monitor #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1'b1), .X_WIDTH(10), .Y_WIDTH(10), .COUNT_WIDTH(19)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .locked(locked), .pixel_valid(pixel_valid), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .pixel_rgb(pixel_rgb), .h_error(h_error),
        .v_error(v_error), .error_count(error_count), .frame_done(frame_done),
        .frame_lit_count(frame_lit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         c;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] rgb;
    } px_t;

    px_t  px_q[$];
    int   lit_q[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, nh = 0, nv = 0, rise_cyc = -1, vs_cyc = 0, gen_lit = 0;
    logic rst_d, locked_prev = 1'b0;
    bit   push_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= reset;
    end

    // Output monitor: pixels and frame totals are popped as the DUT emits them.
    always @(negedge clk) begin
        if (rst_d === 1'b0)
            chk("reset_out", 64'({locked, pixel_valid, pixel_x, pixel_y, pixel_rgb, h_error,
                                  v_error, error_count, frame_done, frame_lit_count}), 64'd0);
        if (h_error) nh <= nh + 1;
        if (v_error) nv <= nv + 1;
        if (locked && !locked_prev) rise_cyc <= cyc;
        locked_prev <= locked;
        if (pixel_valid) begin
            if (px_q.size() == 0)
                chk("px_extra", 64'(pixel_valid), 64'd0);
            else begin
                chk("px", 64'({cyc, pixel_x, pixel_y, pixel_rgb}),
                    64'({px_q[0].c + 3, px_q[0].x, px_q[0].y, px_q[0].rgb}));
                void'(px_q.pop_front());
            end
        end
        if (frame_done) begin
            if (lit_q.size() == 0)
                chk("done_extra", 64'(frame_done), 64'd0);
            else begin
                chk("frame_lit", 64'(frame_lit_count), 64'(lit_q[0]));
                void'(lit_q.pop_front());
            end
        end
    end

    function automatic logic [2:0] pat(input int mode, input int x, input int y);
        case (mode)
            1:       return (x >= 4 && x < 12 && y >= 1 && y < 9) ? 3'b100 : 3'b000;
            2:       return 3'((x + 3 * y + 5) & 7);
            default: return 3'b000;
        endcase
    endfunction

    task automatic send_line(input int v, input int htot, input int hsw, input int mode,
                             input int rst_h);
        px_t p;
        for (int h = 0; h < htot; h++) begin
            @(posedge clk); #1;
            reset = (h == rst_h) ? 1'b0 : 1'b1;
            if (h == rst_h) push_en = 1'b0;
            hsync = !(h < hsw);
            vsync = !(v < VS);
            if (v == 0 && h == 0) vs_cyc = cyc;
            if (h >= HS + HB && h < HS + HB + HD && v >= VS + VB && v < VS + VB + VD) begin
                rgb = pat(mode, h - (HS + HB), v - (VS + VB));
                if (push_en) begin
                    p.c   = cyc;
                    p.x   = 10'(h - (HS + HB));
                    p.y   = 10'(v - (VS + VB));
                    p.rgb = rgb;
                    px_q.push_back(p);
                    if (rgb != 3'b000) gen_lit++;
                end
            end else begin
                rgb = 3'b111;  // blanking junk must never leak into pixel_rgb or lit counts
            end
        end
    endtask

    // err_kind: 1 = first line one clock short, 2 = first hsync pulse one clock short.
    task automatic send_frame(input int nlines, input int mode, input int err_kind,
                              input bit push, input bit done, input int rst_v);
        gen_lit = 0;
        push_en = push;
        for (int v = 0; v < nlines; v++)
            send_line(v, (err_kind == 1 && v == 0) ? HT - 1 : HT,
                      (err_kind == 2 && v == 0) ? HS - 1 : HS, mode,
                      (v == rst_v) ? HS + 1 : -1);
        if (done) lit_q.push_back(gen_lit);
        push_en = 1'b0;
    endtask

    int bvs;

    initial begin
        repeat (4) @(posedge clk);
        for (int v = VT - 3; v < VT; v++) send_line(v, HT, HS, 0, -1);

        send_frame(VT, 2, 0, 0, 0, -1);              // A: first vsync edge, checking
        @(negedge clk); chk("lock_after_A", 64'(locked), 64'd0);
        send_frame(VT, 2, 0, 1, 1, -1);              // B: locked, first pixel 101
        bvs = vs_cyc;
        chk("lock_rise_B", 64'(rise_cyc), 64'(bvs + 3));
        send_frame(VT, 2, 0, 1, 1, -1);              // C
        @(negedge clk);
        chk("nh_nominal", 64'(nh), 64'd0);
        chk("nv_nominal", 64'(nv), 64'd0);
        chk("errcnt_nominal", 64'(error_count), 64'd0);
        chk("locked_nominal", 64'(locked), 64'd1);

        send_frame(VT, 0, 1, 0, 0, -1);              // D: short line
        @(negedge clk);
        chk("nh_short_line", 64'(nh), 64'd1);
        chk("errcnt_short_line", 64'(error_count), 64'd1);
        chk("unlock_short_line", 64'(locked), 64'd0);
        send_frame(VT, 0, 0, 0, 0, -1);              // E: clean check frame
        @(negedge clk); chk("lock_during_E", 64'(locked), 64'd0);
        send_frame(VT, 2, 0, 1, 1, -1);              // F: relocked
        bvs = vs_cyc;
        chk("relock_F", 64'(rise_cyc), 64'(bvs + 3));

        send_frame(VT, 0, 2, 0, 0, -1);              // G: narrow hsync
        @(negedge clk);
        chk("nh_narrow", 64'(nh), 64'd2);
        chk("errcnt_narrow", 64'(error_count), 64'd2);
        chk("unlock_narrow", 64'(locked), 64'd0);
        send_frame(VT, 0, 0, 0, 0, -1);              // H
        send_frame(VT, 2, 0, 1, 1, -1);              // I
        send_frame(VT - 1, 2, 0, 1, 0, -1);          // J: one line short, no frame_done
        send_frame(VT, 0, 0, 0, 0, -1);              // K
        @(negedge clk);
        chk("nv_short_frame", 64'(nv), 64'd1);
        chk("nh_short_frame", 64'(nh), 64'd2);
        chk("errcnt_short_frame", 64'(error_count), 64'd3);
        chk("unlock_short_frame", 64'(locked), 64'd0);

        send_frame(VT, 0, 0, 0, 0, -1);              // L
        send_frame(VT, 1, 0, 1, 1, -1);              // M: 8x8 block
        send_frame(VT, 0, 0, 1, 1, -1);              // N: all black
        send_frame(VT, 2, 0, 1, 0, VS + VB + 2);     // O: reset mid-frame
        @(negedge clk);
        chk("errcnt_after_reset", 64'(error_count), 64'd0);
        chk("lock_after_reset", 64'(locked), 64'd0);
        send_frame(VT, 0, 0, 0, 0, -1);              // P
        @(negedge clk); chk("lock_during_P", 64'(locked), 64'd0);
        send_frame(VT, 2, 0, 1, 1, -1);              // Q
        bvs = vs_cyc;
        chk("relock_Q", 64'(rise_cyc), 64'(bvs + 3));
        send_line(0, HT, HS, 0, -1);
        send_line(1, HT, HS, 0, -1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("px_drained", 64'(px_q.size()), 64'd0);
        chk("lit_drained", 64'(lit_q.size()), 64'd0);
        chk("nh_total", 64'(nh), 64'd2);
        chk("nv_total", 64'(nv), 64'd1);
        chk("errcnt_final", 64'(error_count), 64'd0);
        chk("locked_final", 64'(locked), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
